// File: rtl/dram_controller_if.sv
// ---------------------------------------------------------------------------
// dram_controller_if
//   Bundles the 68000-side strobes/address and the DRAM-side control lines
//   of the expansion DRAM controller.
//
//   CPU side   : AS, UDS, LDS (active-low strobes), RW (1 = read),
//                EXP (active-low region select), ADDR[23:1] (as 23 bits)
//   DRAM side  : DRAM_A (row/column mux), RAS_N, CASU_N, CASL_N, WE_N
//   Handshake  : DTACK_EXP (active-low acknowledge to the system controller)
//
//   slave  : the controller (consumes CPU signals, drives DRAM and DTACK)
//   master : the CPU/system side (drives CPU signals, observes the rest)
// ---------------------------------------------------------------------------
interface dram_controller_if;
    logic        AS;
    logic        UDS;
    logic        LDS;
    logic        RW;
    logic        EXP;
    logic [22:0] ADDR;
    logic [10:0] DRAM_A;
    logic        RAS_N;
    logic        CASU_N;
    logic        CASL_N;
    logic        WE_N;
    logic        DTACK_EXP;

    modport slave (
        input  AS, UDS, LDS, RW, EXP, ADDR,
        output DRAM_A, RAS_N, CASU_N, CASL_N, WE_N, DTACK_EXP
    );

    modport master (
        output AS, UDS, LDS, RW, EXP, ADDR,
        input  DRAM_A, RAS_N, CASU_N, CASL_N, WE_N, DTACK_EXP
    );
endinterface

// File: rtl/dram_controller.sv
// ---------------------------------------------------------------------------
// dram_controller
//   Asynchronous-DRAM controller for the 8 MB expansion region
//   (byte addresses 0x100000-0x8FFFFF) built from a 4M x 16 array.
//   Runs 68000 read/write cycles with multiplexed row/column addressing and
//   inserts CAS-before-RAS refresh every REFRESH_INTERVAL clocks.
//
//   Ports:
//     CLK : oscillator clock (2x CPU clock)
//     RST : synchronous, active-low reset
//     bus : dram_controller_if.slave (CPU strobes/address in, DRAM control
//           and DTACK_EXP out)
//
//   Parameters:
//     REFRESH_INTERVAL : clocks between refresh requests
//     RAS_PRECHARGE    : clocks RAS_N is held high after every cycle (>= 1)
//
//   Every output comes straight from a register; the next-state logic also
//   computes the next output values so that they change together with the
//   state they belong to.
// ---------------------------------------------------------------------------
module dram_controller #(
    parameter int REFRESH_INTERVAL = 300,
    parameter int RAS_PRECHARGE    = 2
) (
    input  logic             CLK,
    input  logic             RST,
    dram_controller_if.slave bus
);
    localparam int RCW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [RCW-1:0] REF_LAST = RCW'(REFRESH_INTERVAL - 1);
    localparam int PCW = (RAS_PRECHARGE > 1) ? $clog2(RAS_PRECHARGE) : 1;
    localparam logic [PCW-1:0] PRE_LOAD = PCW'(RAS_PRECHARGE - 1);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_ROW     = 4'd1;
    localparam logic [3:0] ST_COL     = 4'd2;
    localparam logic [3:0] ST_CAS     = 4'd3;
    localparam logic [3:0] ST_ACK     = 4'd4;
    localparam logic [3:0] ST_PRE     = 4'd5;
    localparam logic [3:0] ST_REF_CAS = 4'd6;
    localparam logic [3:0] ST_REF_RAS = 4'd7;
    localparam logic [3:0] ST_REF_END = 4'd8;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous strobes.
    // Bit order: 0 = AS, 1 = UDS, 2 = LDS, 3 = EXP. Idle (high) on reset.
    // ------------------------------------------------------------------
    logic [3:0] raw_in;
    logic [3:0] sync_out;

    assign raw_in = {bus.EXP, bus.LDS, bus.UDS, bus.AS};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge CLK) begin
                if (!RST) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= raw_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_out[gi] = sync_reg;
        end
    endgenerate

    logic s_as, s_uds, s_lds, s_exp;
    assign s_as  = sync_out[0];
    assign s_uds = sync_out[1];
    assign s_lds = sync_out[2];
    assign s_exp = sync_out[3];

    // Waiting for a data strobe as well as AS guarantees write data is on
    // the bus before CAS falls.
    logic request;
    assign request = !s_as && !s_exp && (!s_uds || !s_lds);

    // Word offset into the array. Inside the decoded region the offset is
    // below 4M words, so bit 22 is always zero and is not needed.
    logic [22:0] word_offset;
    logic        offset_msb_unused;
    assign word_offset       = bus.ADDR - 23'h080000;
    assign offset_msb_unused = word_offset[22];

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    logic [3:0]     state_reg,    state_next;
    logic [PCW-1:0] pre_cnt_reg,  pre_cnt_next;
    logic           ref_wait_reg, ref_wait_next;
    logic [10:0]    col_reg,      col_next;
    logic           rw_reg,       rw_next;
    logic [10:0]    dram_a_reg,   dram_a_next;
    logic           ras_n_reg,    ras_n_next;
    logic           casu_n_reg,   casu_n_next;
    logic           casl_n_reg,   casl_n_next;
    logic           we_n_reg,     we_n_next;
    logic           dtack_reg,    dtack_next;
    logic           ref_clear;

    logic [RCW-1:0] ref_cnt_reg;
    logic           ref_pending_reg;

    always_comb begin
        logic enter_pre;
        enter_pre     = 1'b0;
        ref_clear     = 1'b0;
        state_next    = state_reg;
        pre_cnt_next  = pre_cnt_reg;
        ref_wait_next = ref_wait_reg;
        col_next      = col_reg;
        rw_next       = rw_reg;
        dram_a_next   = dram_a_reg;
        ras_n_next    = ras_n_reg;
        casu_n_next   = casu_n_reg;
        casl_n_next   = casl_n_reg;
        we_n_next     = we_n_reg;
        dtack_next    = dtack_reg;

        case (state_reg)
            ST_IDLE: begin
                // Refresh deliberately wins over a simultaneous request.
                if (ref_pending_reg) begin
                    state_next  = ST_REF_CAS;
                    ref_clear   = 1'b1;
                    casu_n_next = 1'b0;
                    casl_n_next = 1'b0;
                    we_n_next   = 1'b1;
                    ras_n_next  = 1'b1;
                end else if (request) begin
                    // The CPU holds ADDR/RW stable while AS is low, and AS
                    // has been low for two clocks by now.
                    state_next  = ST_ROW;
                    dram_a_next = word_offset[21:11];
                    col_next    = word_offset[10:0];
                    rw_next     = bus.RW;
                    ras_n_next  = 1'b0;
                end
            end
            ST_ROW: begin
                if (s_as) begin
                    enter_pre = 1'b1;
                end else begin
                    state_next  = ST_COL;
                    dram_a_next = col_reg;
                    we_n_next   = rw_reg;   // early write: WE before CAS
                end
            end
            ST_COL: begin
                if (s_as) begin
                    enter_pre = 1'b1;
                end else begin
                    state_next  = ST_CAS;
                    casu_n_next = s_uds;
                    casl_n_next = s_lds;
                end
            end
            ST_CAS: begin
                if (s_as) begin
                    enter_pre = 1'b1;
                end else begin
                    state_next = ST_ACK;
                    dtack_next = 1'b0;
                end
            end
            ST_ACK: begin
                if (s_as) begin
                    enter_pre = 1'b1;
                end
            end
            ST_PRE: begin
                if (pre_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    pre_cnt_next = pre_cnt_reg - 1'b1;
                end
            end
            ST_REF_CAS: begin
                state_next    = ST_REF_RAS;
                ras_n_next    = 1'b0;
                ref_wait_next = 1'b1;
            end
            ST_REF_RAS: begin
                if (!ref_wait_reg) begin
                    state_next  = ST_REF_END;
                    casu_n_next = 1'b1;
                    casl_n_next = 1'b1;
                end else begin
                    ref_wait_next = 1'b0;
                end
            end
            ST_REF_END: begin
                enter_pre = 1'b1;
            end
            default: begin
                enter_pre = 1'b1;
            end
        endcase

        // Every path into precharge releases all strobes and DTACK at once;
        // the address lines keep their last value.
        if (enter_pre) begin
            state_next   = ST_PRE;
            pre_cnt_next = PRE_LOAD;
            ras_n_next   = 1'b1;
            casu_n_next  = 1'b1;
            casl_n_next  = 1'b1;
            we_n_next    = 1'b1;
            dtack_next   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg    <= ST_IDLE;
            pre_cnt_reg  <= '0;
            ref_wait_reg <= 1'b0;
            col_reg      <= '0;
            rw_reg       <= 1'b1;
            dram_a_reg   <= '0;
            ras_n_reg    <= 1'b1;
            casu_n_reg   <= 1'b1;
            casl_n_reg   <= 1'b1;
            we_n_reg     <= 1'b1;
            dtack_reg    <= 1'b1;
        end else begin
            state_reg    <= state_next;
            pre_cnt_reg  <= pre_cnt_next;
            ref_wait_reg <= ref_wait_next;
            col_reg      <= col_next;
            rw_reg       <= rw_next;
            dram_a_reg   <= dram_a_next;
            ras_n_reg    <= ras_n_next;
            casu_n_reg   <= casu_n_next;
            casl_n_reg   <= casl_n_next;
            we_n_reg     <= we_n_next;
            dtack_reg    <= dtack_next;
        end
    end

    // ------------------------------------------------------------------
    // Free-running refresh timer. A single pending flag: refreshes that
    // fall due while one is already pending are not queued. A new wrap
    // takes priority over the clear so a refresh is never lost.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ref_cnt_reg     <= '0;
            ref_pending_reg <= 1'b0;
        end else begin
            if (ref_cnt_reg == REF_LAST) begin
                ref_cnt_reg     <= '0;
                ref_pending_reg <= 1'b1;
            end else begin
                ref_cnt_reg <= ref_cnt_reg + 1'b1;
                if (ref_clear) begin
                    ref_pending_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.DRAM_A    = dram_a_reg;
    assign bus.RAS_N     = ras_n_reg;
    assign bus.CASU_N    = casu_n_reg;
    assign bus.CASL_N    = casl_n_reg;
    assign bus.WE_N      = we_n_reg;
    assign bus.DTACK_EXP = dtack_reg;

endmodule
